// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix scanner, one key at a time, tick-based debounce.
// key/key_valid register on the accepting tick; optional KEYPAD_AUTOREPEAT_EN re-pulses while held.
module keypad_scanner #(
   parameter int SCAN_DIV       = 48000,
   parameter int DEBOUNCE_TICKS = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key,
   output logic       key_valid,
   output logic       key_held
);

   localparam int DIV_W  = $clog2(SCAN_DIV);
   localparam int DCNT_W = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
   localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_TICKS - 1);

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          sync1_q, sync1_d;
   logic [3:0]          rs_q, rs_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
   logic [1:0]          cidx_q, cidx_d;
   logic [1:0]          ridx_q, ridx_d;
   logic [3:0]          col_q, col_d;
   logic [3:0]          key_q, key_d;
   logic                key_valid_q, key_valid_d;
   logic                key_held_q, key_held_d;
   logic                tick;
   logic                row_open;

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int RPT_W = $clog2(4 * DEBOUNCE_TICKS + 1);
   localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(4 * DEBOUNCE_TICKS - 1);
   logic [RPT_W-1:0]    rcnt_q, rcnt_d;
`endif

   function automatic logic [1:0] low_row(input logic [3:0] r);
      logic [1:0] idx;
      if (!r[0])      idx = 2'd0;
      else if (!r[1]) idx = 2'd1;
      else if (!r[2]) idx = 2'd2;
      else            idx = 2'd3;
      return idx;
   endfunction

   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] k;
      case ({r, c})
         4'b00_00: k = 4'h1;
         4'b00_01: k = 4'h2;
         4'b00_10: k = 4'h3;
         4'b00_11: k = 4'hA;
         4'b01_00: k = 4'h4;
         4'b01_01: k = 4'h5;
         4'b01_10: k = 4'h6;
         4'b01_11: k = 4'hB;
         4'b10_00: k = 4'h7;
         4'b10_01: k = 4'h8;
         4'b10_10: k = 4'h9;
         4'b10_11: k = 4'hC;
         4'b11_00: k = 4'hE;
         4'b11_01: k = 4'h0;
         4'b11_10: k = 4'hF;
         default:  k = 4'hD;
      endcase
      return k;
   endfunction

   always_comb begin
      sync1_d     = row;
      rs_d        = sync1_q;
      tick        = (div_q == DIV_LAST);
      div_d       = tick ? '0 : div_q + 1'b1;
      state_d     = state_q;
      dcnt_d      = dcnt_q;
      cidx_d      = cidx_q;
      ridx_d      = ridx_q;
      key_d       = key_q;
      key_valid_d = 1'b0;
      row_open    = rs_q[ridx_q];
`ifdef KEYPAD_AUTOREPEAT_EN
      rcnt_d      = rcnt_q;
`endif

      if (tick) begin
         case (state_q)
            SCAN: begin
               if (rs_q != 4'hF) begin
                  ridx_d  = low_row(rs_q);
                  dcnt_d  = '0;
                  state_d = DEBOUNCE;
               end else begin
                  cidx_d = cidx_q + 2'd1;
               end
            end
            DEBOUNCE: begin
               if (row_open) begin
                  state_d = SCAN;
                  cidx_d  = cidx_q + 2'd1;
               end else if (dcnt_q == DCNT_LAST) begin
                  state_d     = HELD;
                  key_d       = key_map(ridx_q, cidx_q);
                  key_valid_d = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                  rcnt_d      = '0;
`endif
               end else begin
                  dcnt_d = dcnt_q + 1'b1;
               end
            end
            HELD: begin
               if (row_open) begin
                  dcnt_d  = '0;
                  state_d = RELEASE;
               end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                  // Repeat count only advances on ticks actually spent held down.
                  if (rcnt_q == RPT_LAST) begin
                     rcnt_d      = '0;
                     key_valid_d = 1'b1;
                  end else begin
                     rcnt_d = rcnt_q + 1'b1;
                  end
`endif
               end
            end
            RELEASE: begin
               if (!row_open) begin
                  state_d = HELD;
               end else if (dcnt_q == DCNT_LAST) begin
                  state_d = SCAN;
                  cidx_d  = cidx_q + 2'd1;
               end else begin
                  dcnt_d = dcnt_q + 1'b1;
               end
            end
            default: state_d = SCAN;
         endcase
      end

      // Column drive always follows the column index, so it is one-hot-low by construction.
      col_d      = ~(4'd1 << cidx_d);
      key_held_d = (state_d == HELD) || (state_d == RELEASE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= SCAN;
         sync1_q     <= 4'hF;
         rs_q        <= 4'hF;
         div_q       <= '0;
         dcnt_q      <= '0;
         cidx_q      <= 2'd0;
         ridx_q      <= 2'd0;
         col_q       <= 4'b1110;
         key_q       <= 4'h0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
         rcnt_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         sync1_q     <= sync1_d;
         rs_q        <= rs_d;
         div_q       <= div_d;
         dcnt_q      <= dcnt_d;
         cidx_q      <= cidx_d;
         ridx_q      <= ridx_d;
         col_q       <= col_d;
         key_q       <= key_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
`ifdef KEYPAD_AUTOREPEAT_EN
         rcnt_q      <= rcnt_d;
`endif
      end
   end

   assign col       = col_q;
   assign key       = key_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model plus scoreboard of expected key codes.
`timescale 1ns/1ps
module tb_keypad_scanner;
   localparam int SD = 4;
   localparam int DT = 3;
   localparam int ACCEPT_LAT = SD * (DT + 1);

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key;
   logic       key_valid;
   logic       key_held;

   logic [3:0] pmask [4];
   logic [3:0] exp_q [$];
   int n_chk = 0;
   int n_pass = 0;
   int pulses = 0;
   int col_bad = 0;
   int cyc = 0;

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_TICKS(DT)) dut (
      .clk(clk), .reset(reset), .row(row), .col(col),
      .key(key), .key_valid(key_valid), .key_held(key_held)
   );

   always #5 clk = ~clk;

   // A pressed key shorts its row to its column whenever that column is driven low.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         if (|(pmask[r] & ~col)) row[r] = 1'b0;
   end

   always @(posedge clk or posedge reset)
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [3:0] kmap(input int r, input int c);
      logic [15:0] w;
      case (r)
         0:       w = 16'h123A;
         1:       w = 16'h456B;
         2:       w = 16'h789C;
         default: w = 16'hE0FD;
      endcase
      return w[15-4*c -: 4];
   endfunction

   always @(negedge clk) begin
      if (!reset) begin
         if (!(col inside {4'hE, 4'hD, 4'hB, 4'h7})) col_bad++;
         if (key_valid) begin
            pulses++;
            if (exp_q.size() == 0) chk("unexpected_pulse", key, 4'hX);
            else chk("pulse_key", key, exp_q.pop_front());
         end
      end
   end

   task automatic tick_align();
      do @(negedge clk); while (cyc % SD != 0);
   endtask

   task automatic wait_col(input logic [3:0] target, input string tag);
      int n = 0;
      while (col == target && n < 64) begin @(negedge clk); n++; end
      while (col != target && n < 64) begin @(negedge clk); n++; end
      if (col != target) chk(tag, col, target);
   endtask

   task automatic wait_pulse(input int max_n, output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (!key_valid && n < max_n);
   endtask

   task automatic wait_release(input int max_n, output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (key_held && n < max_n);
   endtask

   task automatic press(input int r, input int c);
      pmask[r][c] = 1'b1;
   endtask

   task automatic unpress(input int r, input int c);
      pmask[r][c] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      int p0;
      int t0;
      logic [3:0] exp_col;
      for (int r = 0; r < 4; r++) pmask[r] = 4'h0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_col", col, 4'hE);
      chk("rst_key", key, 4'h0);
      chk("rst_valid", key_valid, 1'b0);
      chk("rst_held", key_held, 1'b0);
      reset = 1'b0;

      // Idle rotation.
      exp_col = 4'hE;
      chk("idle_col_start", col, exp_col);
      for (int i = 0; i < 10; i++) begin
         tick_align();
         exp_col = {exp_col[2:0], exp_col[3]};
         chk("idle_col", col, exp_col);
      end
      chk("idle_pulses", pulses, 0);

      // Key 6 (row1, col2) with a bounce during release.
      wait_col(4'hB, "wait_col_b");
      press(1, 2);
      exp_q.push_back(kmap(1, 2));
      p0 = pulses;
      wait_pulse(200, n);
      chk("k6_latency", n, ACCEPT_LAT);
      chk("k6_held", key_held, 1'b1);
      chk("k6_col_frozen", col, 4'hB);
      unpress(1, 2);
      tick_align();
      chk("k6_held_rel1", key_held, 1'b1);
      press(1, 2);
      tick_align();
      chk("k6_held_bounce", key_held, 1'b1);
      unpress(1, 2);
      wait_release(200, n);
      chk("k6_release_lat", n, ACCEPT_LAT);
      chk("k6_resume_col", col, 4'h7);
      chk("k6_one_pulse", pulses - p0, 1);

      // Key 8 (row2, col1) bouncing during press debounce.
      wait_col(4'hD, "wait_col_d");
      press(2, 1);
      exp_q.push_back(kmap(2, 1));
      p0 = pulses;
      tick_align();
      unpress(2, 1);
      tick_align();
      chk("k8_bounce_col", col, 4'hB);
      chk("k8_bounce_nopulse", pulses - p0, 0);
      press(2, 1);
      wait_pulse(300, n);
      chk("k8_got_pulse", key_valid, 1'b1);
      chk("k8_held", key_held, 1'b1);
      unpress(2, 1);
      wait_release(200, n);
      chk("k8_one_pulse", pulses - p0, 1);

      // Key 5 held while 8 and 9 are also pressed.
      wait_col(4'hD, "wait_col_d2");
      press(1, 1);
      exp_q.push_back(kmap(1, 1));
      p0 = pulses;
      wait_pulse(200, n);
      chk("k5_latency", n, ACCEPT_LAT);
      press(2, 1);
      press(2, 2);
      repeat (40) @(negedge clk);
      chk("k5_no_new_pulse", pulses - p0, 1);
      chk("k5_key_kept", key, 4'h5);
      chk("k5_held", key_held, 1'b1);
      unpress(1, 1);
      unpress(2, 1);
      unpress(2, 2);
      wait_release(200, n);
      chk("k5_released", key_held, 1'b0);

      // Two rows in column 0: lowest row index wins.
      wait_col(4'hE, "wait_col_e");
      press(1, 0);
      press(3, 0);
      exp_q.push_back(kmap(1, 0));
      wait_pulse(200, n);
      chk("k4_latency", n, ACCEPT_LAT);
      unpress(1, 0);
      unpress(3, 0);
      wait_release(200, n);

      // Reset during debounce aborts the press.
      wait_col(4'h7, "wait_col_7");
      press(0, 3);
      p0 = pulses;
      tick_align();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort_col", col, 4'hE);
      chk("abort_key", key, 4'h0);
      chk("abort_valid", key_valid, 1'b0);
      chk("abort_held", key_held, 1'b0);
      unpress(0, 3);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("abort_restart_col", col, 4'hE);
      tick_align();
      chk("abort_next_col", col, 4'hD);
      repeat (20) @(negedge clk);
      chk("abort_nopulse", pulses - p0, 0);

`ifdef KEYPAD_AUTOREPEAT_EN
      // Auto-repeat: acceptance pulse then one every 4*DT held ticks.
      wait_col(4'hE, "wait_col_e2");
      press(0, 0);
      for (int i = 0; i < 3; i++) exp_q.push_back(kmap(0, 0));
      wait_pulse(200, n);
      t0 = cyc;
      wait_pulse(200, n);
      chk("rpt_interval1", cyc - t0, 4 * DT * SD);
      t0 = cyc;
      wait_pulse(200, n);
      chk("rpt_interval2", cyc - t0, 4 * DT * SD);
      repeat (6 * SD) @(negedge clk);
      unpress(0, 0);
      wait_release(200, n);
`else
      t0 = 0;
`endif

      chk("scoreboard_empty", exp_q.size(), 0);
      chk("col_always_valid", col_bad, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
